// File: rtl/id_ex_stage_reg_if.sv
// ID/EX pipeline register bundle: decode-side fields in, execute-side copies out,
// plus the load-use hazard request and the bubble counter.
interface id_ex_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              stall;
   logic              flush;
   logic              id_valid;
   logic [DATA_W-1:0] id_pc_plus4;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [DATA_W-1:0] id_imm_ext;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic [4:0]        id_rd;
   logic [4:0]        id_shamt;
   logic              id_uses_rt;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;
   logic              id_mem_to_reg;
   logic              id_alu_src;
   logic [1:0]        id_reg_dst;
   logic [3:0]        id_alu_op;

   logic              ex_valid;
   logic [DATA_W-1:0] ex_pc_plus4;
   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [DATA_W-1:0] ex_imm_ext;
   logic [4:0]        ex_rs;
   logic [4:0]        ex_rt;
   logic [4:0]        ex_rd;
   logic [4:0]        ex_shamt;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_mem_to_reg;
   logic              ex_alu_src;
   logic [1:0]        ex_reg_dst;
   logic [3:0]        ex_alu_op;
   logic              load_use_stall;
   logic [CNT_W-1:0]  bubble_count;

   modport slave (
      input  stall, flush, id_valid,
      input  id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
      input  id_rs, id_rt, id_rd, id_shamt, id_uses_rt,
      input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
      input  id_reg_dst, id_alu_op,
      output ex_valid,
      output ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
      output ex_rs, ex_rt, ex_rd, ex_shamt,
      output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
      output ex_reg_dst, ex_alu_op,
      output load_use_stall, bubble_count
   );

   modport master (
      output stall, flush, id_valid,
      output id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
      output id_rs, id_rt, id_rd, id_shamt, id_uses_rt,
      output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
      output id_reg_dst, id_alu_op,
      input  ex_valid,
      input  ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
      input  ex_rs, ex_rt, ex_rd, ex_shamt,
      input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
      input  ex_reg_dst, ex_alu_op,
      input  load_use_stall, bubble_count
   );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush/stall control, load-use hazard detection
// (one bubble per load-use pair) and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input logic          clk,
   input logic          rst,
   id_ex_stage_reg_if.slave bus
);

   typedef struct packed {
      logic [DATA_W-1:0] pc_plus4;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm_ext;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [4:0]        shamt;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
      logic              alu_src;
      logic [1:0]        reg_dst;
      logic [3:0]        alu_op;
   } ex_t;

   ex_t              ex_q, ex_d, id_pkt;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hazard;

   // Side-effecting controls of an invalid slot are dropped so a non-instruction
   // can never write the register file or memory downstream.
   always_comb begin
      id_pkt            = '0;
      id_pkt.pc_plus4   = bus.id_pc_plus4;
      id_pkt.rs_data    = bus.id_rs_data;
      id_pkt.rt_data    = bus.id_rt_data;
      id_pkt.imm_ext    = bus.id_imm_ext;
      id_pkt.rs         = bus.id_rs;
      id_pkt.rt         = bus.id_rt;
      id_pkt.rd         = bus.id_rd;
      id_pkt.shamt      = bus.id_shamt;
      id_pkt.reg_write  = bus.id_reg_write & bus.id_valid;
      id_pkt.mem_read   = bus.id_mem_read  & bus.id_valid;
      id_pkt.mem_write  = bus.id_mem_write & bus.id_valid;
      id_pkt.mem_to_reg = bus.id_mem_to_reg;
      id_pkt.alu_src    = bus.id_alu_src;
      id_pkt.reg_dst    = bus.id_reg_dst;
      id_pkt.alu_op     = bus.id_alu_op;
   end

   // Gating on valid_q ends the stall after one bubble: the bubble clears ex_valid.
   assign hazard = bus.id_valid & valid_q & ex_q.mem_read & (ex_q.rt != 5'd0) &
                   ((ex_q.rt == bus.id_rs) | (bus.id_uses_rt & (ex_q.rt == bus.id_rt)));

   always_comb begin
      valid_d = valid_q;
      ex_d    = ex_q;
      cnt_d   = cnt_q;
      if (bus.flush) begin
         valid_d = 1'b0;
         ex_d    = '0;
      end else if (bus.stall) begin
         valid_d = valid_q;
      end else if (hazard) begin
         valid_d = 1'b0;
         ex_d    = '0;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         valid_d = bus.id_valid;
         ex_d    = id_pkt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ex_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ex_q    <= ex_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ex_valid       = valid_q;
   assign bus.ex_pc_plus4    = ex_q.pc_plus4;
   assign bus.ex_rs_data     = ex_q.rs_data;
   assign bus.ex_rt_data     = ex_q.rt_data;
   assign bus.ex_imm_ext     = ex_q.imm_ext;
   assign bus.ex_rs          = ex_q.rs;
   assign bus.ex_rt          = ex_q.rt;
   assign bus.ex_rd          = ex_q.rd;
   assign bus.ex_shamt       = ex_q.shamt;
   assign bus.ex_reg_write   = ex_q.reg_write;
   assign bus.ex_mem_read    = ex_q.mem_read;
   assign bus.ex_mem_write   = ex_q.mem_write;
   assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
   assign bus.ex_alu_src     = ex_q.alu_src;
   assign bus.ex_reg_dst     = ex_q.reg_dst;
   assign bus.ex_alu_op      = ex_q.alu_op;
   assign bus.load_use_stall = hazard;
   assign bus.bubble_count   = cnt_q;

endmodule
